// File: rtl/debug_module_cpu_oci_dtrace_packer.sv
// Packs 10-bit OCI data-trace atoms three to a 30-bit trace RAM word and
// hands each finished or flushed word to the RAM write port.
module debug_module_cpu_oci_dtrace_packer #(
  parameter int ADDR_W  = 7,
  parameter bit WRAP_EN = 1'b1
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              trace_enable,
  input  logic              atom_valid,
  input  logic [9:0]        atom_data,
  output logic              atom_ready,
  input  logic              flush_req,
  input  logic              test_ending,
  output logic              tw_valid,
  output logic [29:0]       tw_data,
  output logic [3:0]        tw_count,
  output logic [ADDR_W-1:0] tw_addr,
  input  logic              tw_ready,
  output logic [29:0]       dct_buffer,
  output logic [3:0]        dct_count,
  output logic              trace_wrapped,
  output logic              trace_full,
  output logic              test_has_ended,
  output logic [1:0]        dbg_state
);

  // Handshakes: an atom moves when atom_valid && atom_ready, a word moves
  // when tw_valid && tw_ready; a word is held unchanged while it waits.
  typedef enum logic [1:0] {FILL = 2'd0, EMIT = 2'd1, ENDED = 2'd2} state_t;

  state_t              r_state;
  state_t              w_state_nxt;
  logic [29:0]         r_buf;
  logic [3:0]          r_count;
  logic [ADDR_W-1:0]   r_addr;
  logic                r_wrapped;
  logic                r_full;
  logic                r_drain;

  logic                w_accept;
  logic                w_hs;
  logic                w_drain_set;
  logic [29:0]         w_buf_acc;
  logic [3:0]          w_cnt_acc;

  assign atom_ready     = (r_state == FILL) && trace_enable && !r_full && !test_ending;
  assign w_accept       = atom_valid && atom_ready;
  assign tw_valid       = (r_state == EMIT);
  assign w_hs           = tw_valid && tw_ready;
  assign tw_data        = r_buf;
  assign tw_count       = r_count;
  assign tw_addr        = r_addr;
  assign dct_buffer     = r_buf;
  assign dct_count      = r_count;
  assign trace_wrapped  = r_wrapped;
  assign trace_full     = r_full;
  assign test_has_ended = (r_state == ENDED);
  assign dbg_state      = r_state;

  // A same-cycle accept lands in the buffer before any flush decision.
  always_comb begin
    w_buf_acc = r_buf;
    w_cnt_acc = r_count;
    if (w_accept) begin
      case (r_count[1:0])
        2'd0:    w_buf_acc[9:0]   = atom_data;
        2'd1:    w_buf_acc[19:10] = atom_data;
        default: w_buf_acc[29:20] = atom_data;
      endcase
      w_cnt_acc = r_count + 4'd1;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_drain_set = 1'b0;
    case (r_state)
      FILL: begin
        if (test_ending) begin
          if (r_count != 4'd0) begin
            w_state_nxt = EMIT;
            w_drain_set = 1'b1;
          end else begin
            w_state_nxt = ENDED;
          end
        end else if (w_cnt_acc == 4'd3) begin
          w_state_nxt = EMIT;
        end else if (flush_req && !r_full && (w_cnt_acc != 4'd0)) begin
          w_state_nxt = EMIT;
        end
      end
      EMIT: begin
        w_drain_set = test_ending;
        if (w_hs) w_state_nxt = (r_drain || test_ending) ? ENDED : FILL;
      end
      default: w_state_nxt = ENDED;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state   <= FILL;
      r_buf     <= '0;
      r_count   <= '0;
      r_addr    <= '0;
      r_wrapped <= 1'b0;
      r_full    <= 1'b0;
      r_drain   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_drain <= r_drain | w_drain_set;
      if (r_state == FILL) begin
        r_buf   <= w_buf_acc;
        r_count <= w_cnt_acc;
      end else if (w_hs) begin
        r_buf   <= '0;
        r_count <= '0;
        r_addr  <= r_addr + 1'b1;
        // Last RAM slot written: the address rolls to 0 either way.
        if (&r_addr) begin
          if (WRAP_EN) r_wrapped <= 1'b1;
          else         r_full    <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_debug_module_cpu_oci_dtrace_packer.sv
// Bench for the trace packer: a wrapping and a non-wrapping instance with
// ADDR_W=2 share stimulus; written words are scored against a model queue.
module tb_debug_module_cpu_oci_dtrace_packer;

  localparam int AW = 2;
  localparam int W  = 30 + 4 + AW;

  logic          clk;
  logic          reset_n;
  logic          trace_enable;
  logic          atom_valid;
  logic [9:0]    atom_data;
  logic          flush_req;
  logic          test_ending;
  logic          tw_ready;

  logic          atom_ready, tw_valid, trace_wrapped, trace_full, test_has_ended;
  logic [29:0]   tw_data, dct_buffer;
  logic [3:0]    tw_count, dct_count;
  logic [AW-1:0] tw_addr;
  logic [1:0]    dbg_state;

  logic          nw_atom_ready, nw_tw_valid, nw_trace_wrapped, nw_trace_full, nw_test_has_ended;
  logic [29:0]   nw_tw_data, nw_dct_buffer;
  logic [3:0]    nw_tw_count, nw_dct_count;
  logic [AW-1:0] nw_tw_addr;
  logic [1:0]    nw_dbg_state;

  logic [W-1:0]  exp_q[$];
  int            n_checks = 0;
  int            n_errors = 0;
  logic [29:0]   m_buf;
  int            m_cnt;
  logic [AW-1:0] m_addr;

  debug_module_cpu_oci_dtrace_packer #(.ADDR_W(AW), .WRAP_EN(1'b1)) dut (
    .clk(clk), .reset_n(reset_n), .trace_enable(trace_enable),
    .atom_valid(atom_valid), .atom_data(atom_data), .atom_ready(atom_ready),
    .flush_req(flush_req), .test_ending(test_ending),
    .tw_valid(tw_valid), .tw_data(tw_data), .tw_count(tw_count), .tw_addr(tw_addr),
    .tw_ready(tw_ready), .dct_buffer(dct_buffer), .dct_count(dct_count),
    .trace_wrapped(trace_wrapped), .trace_full(trace_full),
    .test_has_ended(test_has_ended), .dbg_state(dbg_state)
  );

  debug_module_cpu_oci_dtrace_packer #(.ADDR_W(AW), .WRAP_EN(1'b0)) dut_nw (
    .clk(clk), .reset_n(reset_n), .trace_enable(trace_enable),
    .atom_valid(atom_valid), .atom_data(atom_data), .atom_ready(nw_atom_ready),
    .flush_req(flush_req), .test_ending(test_ending),
    .tw_valid(nw_tw_valid), .tw_data(nw_tw_data), .tw_count(nw_tw_count), .tw_addr(nw_tw_addr),
    .tw_ready(tw_ready), .dct_buffer(nw_dct_buffer), .dct_count(nw_dct_count),
    .trace_wrapped(nw_trace_wrapped), .trace_full(nw_trace_full),
    .test_has_ended(nw_test_has_ended), .dbg_state(nw_dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic model_clear();
    m_buf  = '0;
    m_cnt  = 0;
    m_addr = '0;
    exp_q.delete();
  endtask

  task automatic model_emit();
    exp_q.push_back({m_buf, 4'(m_cnt), m_addr});
    m_addr = m_addr + 1'b1;
    m_buf  = '0;
    m_cnt  = 0;
  endtask

  task automatic model_atom(input logic [9:0] a);
    m_buf[m_cnt*10 +: 10] = a;
    m_cnt++;
    if (m_cnt == 3) model_emit();
  endtask

  // driver tasks
  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    model_clear();
    cycle();
    cycle();
    reset_n = 1'b1;
    cycle();
  endtask

  task automatic drive_atom(input logic [9:0] a);
    atom_valid = 1'b1;
    atom_data  = a;
    model_atom(a);
    cycle();
    atom_valid = 1'b0;
  endtask

  task automatic drive_flush();
    flush_req = 1'b1;
    if (m_cnt > 0) model_emit();
    cycle();
    flush_req = 1'b0;
  endtask

  // scoreboard: a handshake seen at the falling edge completes on the next rise
  always @(negedge clk) begin
    if (reset_n && tw_valid && tw_ready) begin
      if (exp_q.size() == 0) begin
        check("unexpected_word", {tw_data, tw_count, tw_addr}, '0);
      end else begin
        check("word", {tw_data, tw_count, tw_addr}, exp_q.pop_front());
      end
    end
  end

  initial begin
    reset_n = 1'b0; trace_enable = 1'b1; atom_valid = 1'b0; atom_data = '0;
    flush_req = 1'b0; test_ending = 1'b0; tw_ready = 1'b1;
    model_clear();
    #12;
    check("rst_tw_valid", tw_valid, 0);
    check("rst_dct_count", dct_count, 0);
    check("rst_dct_buffer", dct_buffer, 0);
    check("rst_tw_addr", tw_addr, 0);
    check("rst_flags", {trace_wrapped, trace_full, test_has_ended}, 0);
    cycle();
    reset_n = 1'b1;
    cycle();

    // 1: full word
    drive_atom(10'h001); check("t1_cnt1", dct_count, 1);
    drive_atom(10'h002); check("t1_cnt2", dct_count, 2);
    drive_atom(10'h003); check("t1_cnt3", dct_count, 3);
    check("t1_valid", tw_valid, 1);
    check("t1_data", tw_data, 30'h00300801);
    check("t1_count", tw_count, 3);
    check("t1_addr", tw_addr, 0);
    cycle();
    check("t1_cnt_clr", dct_count, 0);
    check("t1_addr_inc", tw_addr, 1);

    // 2: flushed partial word under back-pressure
    tw_ready = 1'b0;
    drive_atom(10'h3FF);
    drive_flush();
    atom_valid = 1'b1; atom_data = 10'h155;
    for (int i = 0; i < 4; i++) begin
      check("t2_valid", tw_valid, 1);
      check("t2_data", tw_data, 30'h000003FF);
      check("t2_count", tw_count, 1);
      check("t2_ready", atom_ready, 0);
      cycle();
    end
    atom_valid = 1'b0;
    tw_ready = 1'b1;
    cycle();
    check("t2_after", {tw_valid, dct_count, tw_addr}, {1'b0, 4'd0, 2'd2});

    // 3: empty flush ignored; accept plus flush in one cycle
    drive_flush();
    check("t3_empty_flush", {tw_valid, dct_count}, 0);
    drive_atom(10'h155);
    tw_ready = 1'b0;
    atom_valid = 1'b1; atom_data = 10'h2AA; flush_req = 1'b1;
    model_atom(10'h2AA); model_emit();
    cycle();
    atom_valid = 1'b0; flush_req = 1'b0;
    check("t3_valid", tw_valid, 1);
    check("t3_count", tw_count, 2);
    tw_ready = 1'b1;
    cycle();

    // 4: address wrap versus full
    do_reset();
    for (int w = 0; w < 5; w++) begin
      for (int k = 0; k < 3; k++) drive_atom(10'($urandom_range(0, 1023)));
      check("t4_addr", tw_addr, w % 4);
      cycle();
      check("t4_wrapped", trace_wrapped, (w >= 3) ? 1 : 0);
      check("t4_full_wrap", trace_full, 0);
      if (w < 4) check("t4_nw_full", nw_trace_full, (w >= 3) ? 1 : 0);
      if (w == 3) begin
        check("t4_nw_addr", nw_tw_addr, 0);
        atom_valid = 1'b1;
        #1;
        check("t4_nw_refuse", nw_atom_ready, 0);
        atom_valid = 1'b0;
      end
    end

    // 5: end-of-test drain, with and without held atoms
    do_reset();
    tw_ready = 1'b0;
    drive_atom(10'h011);
    drive_atom(10'h022);
    test_ending = 1'b1;
    model_emit();
    cycle();
    check("t5_valid", tw_valid, 1);
    check("t5_count", tw_count, 2);
    check("t5_not_ended", test_has_ended, 0);
    tw_ready = 1'b1;
    cycle();
    check("t5_ended", {test_has_ended, tw_valid, atom_ready}, 3'b100);
    test_ending = 1'b0;
    do_reset();
    test_ending = 1'b1;
    cycle();
    check("t5_ended_empty", {test_has_ended, tw_valid}, 2'b10);
    test_ending = 1'b0;

    // 6: asynchronous reset while a word is waiting
    do_reset();
    for (int k = 0; k < 3; k++) drive_atom(10'(k + 16));
    cycle();
    tw_ready = 1'b0;
    for (int k = 0; k < 3; k++) drive_atom(10'(k + 32));
    check("t6_held", {tw_valid, tw_addr}, {1'b1, 2'd1});
    #2;
    reset_n = 1'b0;
    #1;
    check("t6_async", {tw_valid, dct_count, tw_addr}, 0);
    model_clear();
    @(posedge clk); #1;
    reset_n = 1'b1;
    tw_ready = 1'b1;
    cycle();
    for (int k = 0; k < 3; k++) drive_atom(10'($urandom_range(0, 1023)));
    check("t6_resume_addr", tw_addr, 0);

    for (int i = 0; i < 20 && exp_q.size() > 0; i++) cycle();
    check("queue_drained", exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
